// File: rtl/jtframe_sndplay_if.sv
// rtl/jtframe_sndplay_if.sv - recording RAM read port and sound-chip write bus
interface jtframe_sndplay_if #(
    parameter int AW = 13
);
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_data;
    logic          we;
    logic [3:0]    a;
    logic [7:0]    dout;

    modport master (
        output ram_addr,
        output we,
        output a,
        output dout,
        input  ram_data
    );

    modport slave (
        input  ram_addr,
        input  we,
        input  a,
        input  dout,
        output ram_data
    );
endinterface

// File: rtl/jtframe_sndplay.sv
// rtl/jtframe_sndplay.sv - replays recorded sound-register writes paced by v5
module jtframe_sndplay #(
    parameter int AW        = 13,
    parameter int WE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   v5,
    jtframe_sndplay_if.master      bus,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] FETCH   = 3'd1;
    localparam logic [2:0] DECODE  = 3'd2;
    localparam logic [2:0] FETCH_D = 3'd3;
    localparam logic [2:0] LOAD_D  = 3'd4;
    localparam logic [2:0] WRITE   = 3'd5;
    localparam logic [2:0] WAIT_V5 = 3'd6;
    localparam logic [2:0] DONE    = 3'd7;

    localparam int            CW       = $clog2(WE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WE_CYCLES - 1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    logic [2:0]    state;
    logic          v5l;
    logic [3:0]    hdr;
    logic [CW-1:0] cnt;
    logic          last;
    logic          v5_edge;

    assign busy    = (state != IDLE) && (state != DONE);
    assign last    = &bus.ram_addr;
    assign v5_edge = v5 & ~v5l;

    // Every address advance stops at the end of the buffer instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            bus.ram_addr <= '0;
            bus.we       <= 1'b0;
            bus.a        <= 4'd0;
            bus.dout     <= 8'd0;
            done         <= 1'b0;
            err          <= 1'b0;
            v5l          <= 1'b0;
            hdr          <= 4'd0;
            cnt          <= '0;
        end else begin
            v5l <= v5;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        bus.ram_addr <= '0;
                        done         <= 1'b0;
                        err          <= 1'b0;
                        state        <= FETCH;
                    end
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    casez (bus.ram_data)
                        8'h00: begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                        8'h80: state <= WAIT_V5;
                        8'b0001_????: begin
                            hdr <= bus.ram_data[3:0];
                            if (last) begin
                                // header with no room for its data byte
                                err   <= 1'b1;
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                bus.ram_addr <= bus.ram_addr + ADDR_ONE;
                                state        <= FETCH_D;
                            end
                        end
                        default: begin
                            err <= 1'b1;
                            if (last) begin
                                done  <= 1'b1;
                                state <= DONE;
                            end else begin
                                bus.ram_addr <= bus.ram_addr + ADDR_ONE;
                                state        <= FETCH;
                            end
                        end
                    endcase
                end
                FETCH_D: state <= LOAD_D;
                LOAD_D: begin
                    bus.dout <= bus.ram_data;
                    bus.a    <= hdr;
                    bus.we   <= 1'b1;
                    cnt      <= CNT_LOAD;
                    state    <= WRITE;
                end
                WRITE: begin
                    if (cnt == '0) begin
                        bus.we <= 1'b0;
                        if (last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            bus.ram_addr <= bus.ram_addr + ADDR_ONE;
                            state        <= FETCH;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT_V5: begin
                    if (v5_edge) begin
                        if (last) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            bus.ram_addr <= bus.ram_addr + ADDR_ONE;
                            state        <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jtframe_sndplay.sv
// tb/tb_jtframe_sndplay.sv - scoreboard bench for jtframe_sndplay
module tb_jtframe_sndplay;
    localparam int AW = 4;
    localparam int WE = 4;

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        int         edges;
    } wr_t;

    logic clk = 1'b0;
    logic rst, start, v5;
    logic busy, done, err;
    logic [7:0] mem [16];
    wr_t sb[$];
    int total = 0;
    int bad = 0;
    int v5_rises = 0;

    jtframe_sndplay_if #(.AW(AW)) bus ();

    jtframe_sndplay #(.AW(AW), .WE_CYCLES(WE)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .v5    (v5),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.ram_data <= mem[bus.ram_addr];

    // write monitor: pops the scoreboard on each we rise, checks pulse width on fall
    logic we_q = 1'b0;
    int   wcnt = 0;
    always @(negedge clk) begin
        if (rst) begin
            we_q = 1'b0;
            wcnt = 0;
        end else begin
            if (bus.we && !we_q) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write a=%h dout=%h edges=%0d required no write",
                             bus.a, bus.dout, v5_rises);
                end else begin
                    wr_t e;
                    e = sb.pop_front();
                    if (bus.a !== e.a || bus.dout !== e.d || v5_rises !== e.edges) begin
                        bad++;
                        $display("FAIL write_data a=%h dout=%h edges=%0d required a=%h dout=%h edges=%0d",
                                 bus.a, bus.dout, v5_rises, e.a, e.d, e.edges);
                    end
                end
                wcnt = 1;
            end else if (bus.we) begin
                wcnt++;
            end else if (we_q) begin
                total++;
                if (wcnt !== WE) begin
                    bad++;
                    $display("FAIL we_width got=%0d required=%0d", wcnt, WE);
                end
            end
            we_q = bus.we;
        end
    end

    task automatic clear_mem(input logic [7:0] fill);
        for (int i = 0; i < 16; i++) mem[i] = fill;
    endtask

    task automatic push(input logic [3:0] a, input logic [7:0] d, input int edges);
        wr_t e;
        e.a = a; e.d = d; e.edges = edges;
        sb.push_back(e);
    endtask

    // returns at the negedge of the first cycle after start is sampled
    task automatic do_start;
        v5_rises = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL %s_timeout done=%b required=1 after %0d cycles", tag, done, budget);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; v5 = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({bus.ram_addr, bus.we, bus.a, bus.dout, busy, done, err} !== '0) begin
            bad++;
            $display("FAIL reset_values addr=%h we=%b a=%h dout=%h busy=%b done=%b err=%b required all 0",
                     bus.ram_addr, bus.we, bus.a, bus.dout, busy, done, err);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset busy=%b done=%b required 0 0", busy, done);
        end
    endtask

    task automatic test_single_write;
        int first_we, done_k;
        clear_mem(8'h00);
        mem[0] = 8'h12; mem[1] = 8'h34; mem[2] = 8'h00;
        push(4'h2, 8'h34, 0);
        do_start();
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL busy_after_start busy=%b done=%b required 1 0", busy, done);
        end
        first_we = 0; done_k = 0;
        for (int k = 2; k <= 40 && done_k == 0; k++) begin
            @(negedge clk);
            if (bus.we && first_we == 0) first_we = k;
            if (done) done_k = k;
        end
        total++;
        if (first_we !== 5) begin
            bad++;
            $display("FAIL we_latency got=%0d required=5", first_we);
        end
        total++;
        if (done_k !== 11) begin
            bad++;
            $display("FAIL done_latency got=%0d required=11", done_k);
        end
        total++;
        if (bus.ram_addr !== 4'd2 || busy !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL single_end addr=%0d busy=%b err=%b required 2 0 0", bus.ram_addr, busy, err);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL single_pending got=%0d required=0", sb.size());
        end
    endtask

    task automatic test_v5_paced;
        int n;
        clear_mem(8'h00);
        mem[0] = 8'h80; mem[1] = 8'h15; mem[2] = 8'hAA; mem[3] = 8'h80;
        mem[4] = 8'h1F; mem[5] = 8'h01; mem[6] = 8'h00;
        push(4'h5, 8'hAA, 1);
        push(4'hF, 8'h01, 2);
        v5 = 1'b0;
        do_start();
        n = 0;
        while (!done && n < 6) begin
            repeat (20) @(negedge clk);
            v5 = 1'b1; v5_rises++;
            repeat (20) @(negedge clk);
            v5 = 1'b0;
            n++;
        end
        total++;
        if (done !== 1'b1 || v5_rises !== 2 || err !== 1'b0) begin
            bad++;
            $display("FAIL paced_end done=%b edges=%0d err=%b required 1 2 0", done, v5_rises, err);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL paced_pending got=%0d required=0", sb.size());
        end
    endtask

    task automatic test_v5_same_cycle;
        clear_mem(8'h00);
        mem[0] = 8'h80; mem[1] = 8'h15; mem[2] = 8'hAA; mem[3] = 8'h00;
        push(4'h5, 8'hAA, 2);
        v5 = 1'b0;
        do_start();
        @(negedge clk);
        v5 = 1'b1; v5_rises++;
        repeat (10) @(negedge clk);
        total++;
        if (busy !== 1'b1 || bus.ram_addr !== 4'd0) begin
            bad++;
            $display("FAIL same_cycle_edge busy=%b addr=%0d required 1 0", busy, bus.ram_addr);
        end
        v5 = 1'b0;
        repeat (3) @(negedge clk);
        v5 = 1'b1; v5_rises++;
        wait_done(50, "same_cycle");
        v5 = 1'b0;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL same_cycle_pending got=%0d required=0", sb.size());
        end
    endtask

    task automatic test_err_skip;
        clear_mem(8'h00);
        mem[0] = 8'h42; mem[1] = 8'h11; mem[2] = 8'h77; mem[3] = 8'h00;
        push(4'h1, 8'h77, 0);
        do_start();
        wait_done(100, "err_skip");
        total++;
        if (err !== 1'b1 || bus.ram_addr !== 4'd3 || sb.size() != 0) begin
            bad++;
            $display("FAIL err_skip err=%b addr=%0d pending=%0d required 1 3 0", err, bus.ram_addr, sb.size());
        end
        push(4'h1, 8'h77, 0);
        do_start();
        total++;
        if (err !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL restart_clear err=%b done=%b required 0 0", err, done);
        end
        wait_done(100, "err_rerun");
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL err_rerun err=%b required=1", err);
        end
    endtask

    task automatic test_full_wait;
        clear_mem(8'h80);
        v5 = 1'b0;
        do_start();
        for (int i = 1; i <= 16; i++) begin
            repeat (4) @(negedge clk);
            v5 = 1'b1; v5_rises++;
            repeat (4) @(negedge clk);
            v5 = 1'b0;
            if (i == 15) begin
                total++;
                if (done !== 1'b0 || busy !== 1'b1 || bus.ram_addr !== 4'd15) begin
                    bad++;
                    $display("FAIL full_15th done=%b busy=%b addr=%0d required 0 1 15", done, busy, bus.ram_addr);
                end
            end
        end
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || bus.ram_addr !== 4'd15 || err !== 1'b0) begin
            bad++;
            $display("FAIL full_end done=%b busy=%b addr=%0d err=%b required 1 0 15 0",
                     done, busy, bus.ram_addr, err);
        end
    endtask

    task automatic test_last_header;
        int n;
        clear_mem(8'h00);
        for (int i = 0; i < 7; i++) begin
            mem[2*i]   = 8'h10 | 8'(i);
            mem[2*i+1] = 8'(i);
            push(4'(i), 8'(i), 0);
        end
        mem[14] = 8'h80; mem[15] = 8'h13;
        v5 = 1'b0;
        do_start();
        n = 0;
        while (!(busy && bus.ram_addr == 4'd14) && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        total++;
        if (err !== 1'b0 || done !== 1'b0 || bus.ram_addr !== 4'd14) begin
            bad++;
            $display("FAIL last_pre err=%b done=%b addr=%0d required 0 0 14", err, done, bus.ram_addr);
        end
        v5 = 1'b1; v5_rises++;
        wait_done(50, "last_header");
        v5 = 1'b0;
        total++;
        if (err !== 1'b1 || bus.ram_addr !== 4'd15 || sb.size() != 0) begin
            bad++;
            $display("FAIL last_header err=%b addr=%0d pending=%0d required 1 15 0", err, bus.ram_addr, sb.size());
        end
    endtask

    task automatic test_rst_mid_write;
        int n;
        clear_mem(8'h00);
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h80;
        mem[3] = 8'h13; mem[4] = 8'h44; mem[5] = 8'h00;
        push(4'h1, 8'h22, 0);
        push(4'h3, 8'h44, 1);
        v5 = 1'b0;
        do_start();
        n = 0;
        while (!(busy && bus.ram_addr == 4'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        start = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (bus.ram_addr !== 4'd2 || busy !== 1'b1) begin
            bad++;
            $display("FAIL start_ignored addr=%0d busy=%b required 2 1", bus.ram_addr, busy);
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        v5 = 1'b1; v5_rises++;
        n = 0;
        while (!bus.we && n < 30) begin
            @(negedge clk);
            n++;
        end
        #2 rst = 1'b1;
        #1;
        total++;
        if (bus.we !== 1'b0 || busy !== 1'b0 || bus.a !== 4'd0 || bus.dout !== 8'd0) begin
            bad++;
            $display("FAIL async_reset we=%b busy=%b a=%h dout=%h required 0 0 0 00",
                     bus.we, busy, bus.a, bus.dout);
        end
        repeat (2) @(negedge clk);
        total++;
        if (done !== 1'b0 || bus.ram_addr !== 4'd0 || sb.size() != 0) begin
            bad++;
            $display("FAIL reset_end done=%b addr=%0d pending=%0d required 0 0 0", done, bus.ram_addr, sb.size());
        end
        rst = 1'b0;
        v5 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        clear_mem(8'h00);
        test_reset();
        test_single_write();
        test_v5_paced();
        test_v5_same_cycle();
        test_err_skip();
        test_full_wait();
        test_last_header();
        test_rst_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/jtframe_sndplay.md
# jtframe_sndplay

Playback stage for sound-register recordings. Reads the byte stream produced by the sound recorder from a synchronous RAM and re-issues the logged register writes to a sound-chip bus, paced by the same 240 Hz `v5` tick. Used in simulation and for on-board replay of captured sound sessions. Sits directly downstream of the recorder's buffer: the recorder's output RAM is this block's input.

## Interface
Parameters:
- `AW`, 13, recording RAM address width; buffer is 2^AW bytes.
- `WE_CYCLES`, 4, width of each `we` pulse in clk cycles (≥1).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `start`  in  1  begin playback from address 0; level-sampled.
- `v5`  in  1  240 Hz pacing tick; rising edge = one frame slot.
- `ram_addr`  out  AW  recording RAM read address.
- `ram_data`  in  8  RAM read data, valid 1 cycle after `ram_addr`.
- `we`  out  1  sound-chip write strobe.
- `a`  out  4  sound-chip register address.
- `dout`  out  8  sound-chip write data.
- `busy`  out  1  high while playback active.
- `done`  out  1  high after playback ends; cleared by `start`.
- `err`  out  1  sticky: undecodable byte seen; cleared by `start`.

## Operation
Stream encoding, per record:
- `00` → end of stream.
- `80` → wait for the next `v5` rising edge.
- `1x` (0x10–0x1F) → write; next byte is data; `a`=x.
- Any other value → `err`=1, byte skipped, continue.

States:
- IDLE: `busy`=0. `start`=1 → `ram_addr`=0, `done`=0, `err`=0, go FETCH.
- FETCH: one cycle for RAM latency → DECODE.
- DECODE: classify `ram_data`. `00` → DONE. `80` → WAIT_V5. `1x` → latch x, increment address, go FETCH_D. Other → set `err`, increment address, go FETCH.
- FETCH_D: one-cycle latency → LOAD_D.
- LOAD_D: `dout`←`ram_data`, `a`←latched x, `we`=1, go WRITE.
- WRITE: hold `we` high for `WE_CYCLES` total cycles, then `we`=0, increment address, go FETCH.
- WAIT_V5: on a rising edge detected while in this state, increment address, go FETCH.
- DONE: `busy`=0, `done`=1. `start`=1 restarts as in IDLE.

Rules:
- `v5l` is registered every cycle in every state. Edge = `v5 & ~v5l`. Only edges seen in a WAIT_V5 cycle count; earlier edges are not queued.
- `start` is ignored while `busy`=1.
- End of buffer: any increment from address 2^AW−1 goes to DONE instead of wrapping. `done`=1, `err` unchanged. This includes a `1x` header in the last byte; its write is dropped and `err`=1.
- `a`/`dout` hold their value until the next LOAD_D.

## Timing
- Reset values: `ram_addr`=0, `we`=0, `a`=0, `dout`=0, `busy`=0, `done`=0, `err`=0, `v5l`=0, state IDLE.
- `start` high at edge N → FETCH at N+1 with `ram_addr`=0. `busy`=1 from N+1.
- Header decode: 2 cycles per byte (FETCH + DECODE).
- Write record: header decoded at cycle D. `we` rises at D+3 together with valid `a`/`dout`, stays high `WE_CYCLES` cycles. Next FETCH at D+3+`WE_CYCLES`.
- `80` decoded at D: WAIT_V5 from D+1. Edge seen at cycle E → FETCH at E+1.
- `00` decoded at D → `busy`=0 and `done`=1 at D+1.
- Reset mid-write forces `we`=0 immediately (asynchronous).

## Test plan
- Stream `12 34 00`: after `start`, `we` high for 4 cycles with `a`=2, `dout`=0x34. Then `done`=1, `busy`=0, `ram_addr`=2.
- Stream `80 15 AA 80 1F 01 00`, `v5` toggled at 4 kHz-equivalent: each write occurs only after a distinct `v5` rise. Writes (5,AA) and (F,01) are in order. No write happens before the first edge.
- `v5` rising in the same cycle the `80` byte is decoded: that edge is ignored and the block waits for the following edge.
- Stream `42 11 77 00`: `err`=1 and the 0x42 byte is skipped. Write (1,77) still issued, then `done`. A new `start` clears `err` and `done`.
- RAM fully filled with `80`, AW=4, 16 `v5` edges: `done`=1 after the 16th edge, `ram_addr` does not wrap to 0. Last byte `13` with AW=4: no `we`, `err`=1, `done`=1.
- Assert `rst` while `we`=1: `we`, `busy`, `a`, `dout` reach 0 without a clock edge. `start` is ignored while `busy`=1.
